// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the retire trace FIFO.
package trace_pkg;
  localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] wdata;
  } trace_rec_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} trace_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO storage with wrapping pointers and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // Storage is never reset; only entries below count are ever observed.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  assign rdata = mem[rptr];
endmodule

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: buffers retired-instruction records, counts drops when full,
// and stops accepting after a syscall retires, signalling done once drained.
module retire_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic [4:0]       commit_rd,
  input  logic             commit_wr,
  input  logic [31:0]      commit_wdata,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_instr,
  output logic [4:0]       trace_rd,
  output logic             trace_wr,
  output logic [31:0]      trace_wdata,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             done
);
  trace_state_t state, state_nx;
  trace_rec_t rec, head;
  logic run, full, push, pop, drop;
  assign run         = state == RUN;
  assign full        = count == CW'(DEPTH);
  assign trace_valid = count != '0;
  assign pop         = trace_valid & trace_ready;
  assign push        = commit_valid & run & (!full | pop);
  assign drop        = commit_valid & run & full & !pop;
  assign done        = state == DONE;
  assign rec = '{pc: commit_pc, instr: commit_instr, rd: commit_rd, wr: commit_wr, wdata: commit_wdata};
  sync_fifo #(.WIDTH($bits(trace_rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (rec),
    .rdata (head),
    .count (count)
  );
  assign trace_pc    = head.pc;
  assign trace_instr = head.instr;
  assign trace_rd    = head.rd;
  assign trace_wr    = head.wr;
  assign trace_wdata = head.wdata;
  // A syscall ends the program whether or not its record fit in the buffer.
  always_comb begin
    state_nx = state;
    if (run && commit_valid && commit_instr == SYSCALL_INSTR) state_nx = DRAIN;
    if (state == DRAIN && (count == '0 || (count == CW'(1) && pop))) state_nx = DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= RUN;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb_retire_trace_fifo: random and directed stimulus checked every cycle against a queue model.
module tb_retire_trace_fifo;
  import trace_pkg::*;
  localparam int DEPTH = 16;
  localparam int CNT_W = 3;
  logic clk = 0, reset = 0;
  logic commit_valid = 0, commit_wr = 0, trace_ready = 0;
  logic [31:0] commit_pc = 0, commit_instr = 0, commit_wdata = 0;
  logic [4:0] commit_rd = 0;
  logic trace_valid, trace_wr, overflow, done;
  logic [31:0] trace_pc, trace_instr, trace_wdata;
  logic [4:0] trace_rd;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] drop_cnt;
  int tests = 0, fails = 0;
  trace_rec_t mq[$];
  bit m_drain, m_done, m_ovf;
  int m_drops;

  always #5 clk = ~clk;

  retire_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_rd(commit_rd), .commit_wr(commit_wr), .commit_wdata(commit_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_rd(trace_rd),
    .trace_wr(trace_wr), .trace_wdata(trace_wdata),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .done(done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ni();
    return $urandom | 32'h100;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drain = 0;
    m_done  = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic compare();
    chk("count", 128'(count), 128'(mq.size()));
    chk("trace_valid", 128'(trace_valid), 128'(mq.size() != 0));
    if (mq.size() != 0)
      chk("head", 128'({trace_pc, trace_instr, trace_rd, trace_wr, trace_wdata}), 128'(mq[0]));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drops));
    chk("done", 128'(done), 128'(m_done));
  endtask

  // Drive one cycle at a negedge, advance the model past the coming posedge, then compare.
  task automatic step(input bit cv, input logic [31:0] pc, input logic [31:0] instr, input bit rdy);
    trace_rec_t r;
    bit pop, acc, was_drain;
    r = '{pc: pc, instr: instr, rd: 5'($urandom), wr: 1'($urandom), wdata: $urandom};
    commit_valid = cv;
    commit_pc = r.pc;
    commit_instr = r.instr;
    commit_rd = r.rd;
    commit_wr = r.wr;
    commit_wdata = r.wdata;
    trace_ready = rdy;
    pop = mq.size() != 0 && rdy;
    was_drain = m_drain && !m_done;
    acc = 0;
    if (cv && !m_drain) begin
      if (mq.size() < DEPTH || pop) acc = 1;
      else begin
        m_ovf = 1;
        if (m_drops < (1 << CNT_W) - 1) m_drops++;
      end
      if (instr == SYSCALL_INSTR) m_drain = 1;
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(r);
    if (was_drain && mq.size() == 0) m_done = 1;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 0;
    commit_valid = 0;
    trace_ready = 0;
    model_reset();
    @(negedge clk);
    chk("rst_count", 128'(count), 0);
    chk("rst_valid", 128'(trace_valid), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_overflow", 128'(overflow), 0);
    chk("rst_drop", 128'(drop_cnt), 0);
    reset = 1;
  endtask

  initial begin
    int n;
    bit cv;
    do_reset();
    // In-order passthrough of three commits
    step(1, 32'h0, ni(), 1);
    chk("p1_valid", 128'(trace_valid), 1);
    chk("p1_pc0", 128'(trace_pc), 128'h0);
    step(1, 32'h4, ni(), 1);
    chk("p1_pc4", 128'(trace_pc), 128'h4);
    step(1, 32'h8, ni(), 1);
    chk("p1_pc8", 128'(trace_pc), 128'h8);
    step(0, 0, 0, 1);
    chk("p1_empty", 128'(count), 0);
    // Overflow with 20 commits into 16 entries
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 32'(i * 4), ni(), 0);
    chk("p2_count", 128'(count), 16);
    chk("p2_overflow", 128'(overflow), 1);
    chk("p2_drop", 128'(drop_cnt), 4);
    chk("p2_head", 128'(trace_pc), 0);
    step(1, 32'h100, ni(), 1);
    chk("p2_full_pp_count", 128'(count), 16);
    chk("p2_full_pp_drop", 128'(drop_cnt), 4);
    chk("p2_full_pp_head", 128'(trace_pc), 128'h4);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1);
    chk("p2_drained", 128'(count), 0);
    for (int i = 0; i < 26; i++) step(1, 32'(32'h1000 + i * 4), ni(), 0);
    chk("p2_saturate", 128'(drop_cnt), 7);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1);
    // Syscall ends the program
    do_reset();
    step(1, 32'h10, ni(), 0);
    step(1, 32'h14, ni(), 0);
    step(1, 32'h18, SYSCALL_INSTR, 0);
    for (int i = 0; i < 3; i++) step(1, 32'(32'h20 + i * 4), ni(), 0);
    chk("p3_count", 128'(count), 3);
    chk("p3_not_done", 128'(done), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("p3_still_not_done", 128'(done), 0);
    step(1, 32'h40, ni(), 1);
    chk("p3_done", 128'(done), 1);
    chk("p3_empty", 128'(count), 0);
    for (int i = 0; i < 3; i++) step(1, 32'(32'h50 + i * 4), ni(), 1);
    chk("p3_ignored", 128'(count), 0);
    chk("p3_drop", 128'(drop_cnt), 0);
    // Syscall dropped at full
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'(i * 4), ni(), 0);
    step(1, 32'h500, SYSCALL_INSTR, 0);
    chk("p4_overflow", 128'(overflow), 1);
    chk("p4_drop", 128'(drop_cnt), 1);
    step(1, 32'h504, ni(), 0);
    step(1, 32'h508, ni(), 0);
    chk("p4_drop_hold", 128'(drop_cnt), 1);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1);
    chk("p4_done", 128'(done), 1);
    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'(i * 4), ni(), 0);
    chk("p5_count5", 128'(count), 5);
    #2 reset = 0;
    #1;
    chk("p5_async_count", 128'(count), 0);
    chk("p5_async_valid", 128'(trace_valid), 0);
    chk("p5_async_done", 128'(done), 0);
    model_reset();
    commit_valid = 0;
    @(negedge clk);
    reset = 1;
    step(1, 32'h700, ni(), 0);
    chk("p5_resume_pc", 128'(trace_pc), 128'h700);
    chk("p5_resume_count", 128'(count), 1);
    // 100-commit stream with random backpressure
    do_reset();
    n = 0;
    while (n < 100) begin
      cv = $urandom_range(0, 3) != 0;
      step(cv, 32'(n * 4), ni(), 1'($urandom));
      if (cv) n++;
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1);
    chk("p6_drained", 128'(count), 0);
    // Random traffic with occasional syscalls
    do_reset();
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 32'(i * 4), $urandom_range(0, 63) == 0 ? SYSCALL_INSTR : ni(), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/retire_trace_fifo.md
RETIRE_TRACE_FIFO -- requirements
Module: retire_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; power of two, minimum 2.
REQ-002 Parameter CNT_W, default 16, width of the dropped-commit counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-005 commit_valid  in  1  CPU retired one instruction this cycle.
REQ-006 commit_pc  in  32  PC of retired instruction.
REQ-007 commit_instr  in  32  instruction word.
REQ-008 commit_rd  in  5  destination register index (rd, rt or 31 for link).
REQ-009 commit_wr  in  1  destination register written.
REQ-010 commit_wdata  in  32  value written to destination.
REQ-011 trace_valid  out  1  head entry available.
REQ-012 trace_ready  in  1  consumer accepts head entry.
REQ-013 trace_pc, trace_instr, trace_rd, trace_wr, trace_wdata  out  32/32/5/1/32  head entry fields.
REQ-014 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  out  1  sticky: at least one commit dropped.
REQ-016 drop_cnt  out  CNT_W  number of dropped commits, saturating.
REQ-017 done  out  1  end-of-program commit seen and all entries drained.

Function
REQ-018 Push when commit_valid=1, state=RUN, and (count<DEPTH or pop in same cycle).
REQ-019 Pop when trace_valid=1 and trace_ready=1; head advances next edge.
REQ-020 trace_valid = (count!=0), driven from registered state; a pushed entry is visible 1 cycle after the commit edge, with no bypass when empty.
REQ-021 trace_* fields reflect the head entry whenever trace_valid=1; they are don't-care otherwise.
REQ-022 The entry at the head, and trace_* fields, hold stable while trace_valid=1 and trace_ready=0.
REQ-023 Push and pop together: count unchanged; at full, the push is accepted.
REQ-024 Commit in RUN with count=DEPTH and no pop: entry dropped; overflow<=1; drop_cnt increments, holding at all-ones.
REQ-025 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 FSM states: RUN, DRAIN, DONE.
REQ-027 RUN->DRAIN on an accepted push whose commit_instr=32'h0000000C (syscall); the syscall entry is enqueued.
REQ-028 A syscall commit dropped at full sets overflow and still moves to DRAIN.
REQ-029 In DRAIN and DONE, commits are ignored: no push, no drop count.
REQ-030 DRAIN->DONE on the edge where count becomes 0, or immediately if count=0; done=1 only in DONE.
REQ-031 DONE is terminal until reset.

Reset
REQ-032 While reset=0: state=RUN; pointers=0; count=0; trace_valid=0; overflow=0; drop_cnt=0; done=0.
REQ-033 Reset asserted mid-operation discards all entries immediately and asynchronously; storage contents need no reset.
REQ-034 The first push is accepted on the first rising edge after reset deasserts.

Structure
REQ-035 Shared package trace_pkg holds: trace_rec_t packed struct {pc, instr, rd, wr, wdata}; SYSCALL_INSTR=32'h0000000C; trace_state_t enum {RUN, DRAIN, DONE}.
REQ-036 Storage and pointers live in one sub-module, sync_fifo, parameterised by width and depth; retire_trace_fifo adds the FSM, drop accounting and record packing.

Verification
REQ-037 After reset, 3 commits (pc 0x0,0x4,0x8), trace_ready=1 -> trace_valid from cycle after first commit; 3 entries out in order; count returns to 0.
REQ-038 DEPTH=16, trace_ready=0, 20 commits -> count=16; overflow=1; drop_cnt=4; entries out are the first 16 pcs.
REQ-039 Full FIFO, commit and trace_ready=1 in the same cycle -> count stays 16; drop_cnt unchanged.
REQ-040 Commit 0x0000000C with 2 entries queued, then further commits, ready=1 -> done=1 once the syscall entry pops; later commits absent from output; drop_cnt unchanged.
REQ-041 Reset pulsed low mid-stream with count=5 -> count=0, trace_valid=0, done=0 asynchronously; normal pushes resume afterwards.
REQ-042 Backpressure: trace_ready toggling randomly with a 100-commit stream -> output matches a reference queue exactly; trace_* stable while stalled.
